// File: rtl/fpu_pkg.sv
// ============================================================================
// fpu_pkg : shared FPU constants, controller state type and fflags indices
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'd255;

    // fflags bit positions, RISC-V order {NV,DZ,OF,UF,NX}
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

endpackage

`default_nettype wire

// File: rtl/lzc28.sv
// ============================================================================
// lzc28 : combinational leading-zero counter, 28-bit input, count 0..28
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lzc28 (
    input  logic [27:0] i_data,
    output logic [4:0]  o_count
);

    // Scanning upward lets the highest set bit make the final assignment.
    always_comb begin
        o_count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (i_data[i]) o_count = 5'(27 - i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_sub.sv
// ============================================================================
// fp_sub : multi-cycle IEEE-754 single-precision subtractor (a - b), RNE
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fp_sub
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    state_t             r_state, w_next;
    logic [31:0]        r_a, r_b;
    logic               r_special, r_sign, r_sub, r_zero;
    logic [31:0]        r_spec_res;
    logic [4:0]         r_spec_ff;
    logic signed [9:0]  r_exp;
    logic [26:0]        r_sig_l, r_sig_s, r_sig;
    logic [27:0]        r_sum;
    logic [31:0]        r_result;
    logic [4:0]         r_fflags;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_ALIGN;
            ST_ALIGN: w_next = ST_ADD;
            ST_ADD:   w_next = ST_NORM;
            ST_NORM:  w_next = ST_ROUND;
            ST_ROUND: w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ---------------- ALIGN: unpack, classify, swap, shift ----------------
    logic        w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic        w_spec, w_a_ge;
    logic [31:0] w_spec_res;
    logic [4:0]  w_spec_ff;
    logic [7:0]  w_big_exp, w_diff;
    logic [26:0] w_sig_a, w_sig_b, w_sig_big, w_sig_small, w_shifted, w_sig_al;
    logic        w_lost;

    assign w_sa     = r_a[31];
    assign w_sb     = ~r_b[31];
    assign w_a_nan  = (r_a[30:23] == EXP_MAX) && (r_a[22:0] != 23'd0);
    assign w_b_nan  = (r_b[30:23] == EXP_MAX) && (r_b[22:0] != 23'd0);
    assign w_a_inf  = (r_a[30:23] == EXP_MAX) && (r_a[22:0] == 23'd0);
    assign w_b_inf  = (r_b[30:23] == EXP_MAX) && (r_b[22:0] == 23'd0);
    assign w_a_zero = (r_a[30:23] == 8'd0);
    assign w_b_zero = (r_b[30:23] == 8'd0);

    always_comb begin
        w_spec     = 1'b1;
        w_spec_res = 32'd0;
        w_spec_ff  = 5'd0;
        if (w_a_nan || w_b_nan) begin
            w_spec_res       = QNAN;
            w_spec_ff[FF_NV] = (w_a_nan && !r_a[22]) || (w_b_nan && !r_b[22]);
        end else if (w_a_inf && w_b_inf) begin
            if (w_sa == w_sb) begin
                w_spec_res = {w_sa, EXP_MAX, 23'd0};
            end else begin
                w_spec_res       = QNAN;
                w_spec_ff[FF_NV] = 1'b1;
            end
        end else if (w_a_inf) begin
            w_spec_res = {w_sa, EXP_MAX, 23'd0};
        end else if (w_b_inf) begin
            w_spec_res = {w_sb, EXP_MAX, 23'd0};
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res = {w_sa & w_sb, 31'd0};
        end else if (w_a_zero) begin
            w_spec_res = {w_sb, r_b[30:0]};
        end else if (w_b_zero) begin
            w_spec_res = r_a;
        end else begin
            w_spec = 1'b0;
        end
    end

    assign w_a_ge      = r_a[30:0] >= r_b[30:0];
    assign w_sig_a     = {1'b1, r_a[22:0], 3'b000};
    assign w_sig_b     = {1'b1, r_b[22:0], 3'b000};
    assign w_sig_big   = w_a_ge ? w_sig_a : w_sig_b;
    assign w_sig_small = w_a_ge ? w_sig_b : w_sig_a;
    assign w_big_exp   = w_a_ge ? r_a[30:23] : r_b[30:23];
    assign w_diff      = w_a_ge ? (r_a[30:23] - r_b[30:23]) : (r_b[30:23] - r_a[30:23]);
    assign w_shifted   = w_sig_small >> w_diff;
    assign w_lost      = |(w_sig_small & ~({27{1'b1}} << w_diff));
    assign w_sig_al    = (w_diff >= 8'd27) ? 27'd1
                                           : {w_shifted[26:1], w_shifted[0] | w_lost};

    // ---------------- NORM / ROUND helpers ----------------
    logic [4:0]        w_lz, w_lsh;
    logic              w_up;
    logic [24:0]       w_m25;
    logic [22:0]       w_man;
    logic signed [9:0] w_exp_r;

    lzc28 u_lzc (
        .i_data  (r_sum),
        .o_count (w_lz)
    );

    // The 28-bit count includes the (empty) carry bit, so normalise by one less.
    assign w_lsh   = w_lz - 5'd1;
    assign w_up    = r_sig[2] & (r_sig[1] | r_sig[0] | r_sig[3]);
    assign w_m25   = {1'b0, r_sig[26:3]} + {24'd0, w_up};
    assign w_man   = w_m25[24] ? w_m25[23:1] : w_m25[22:0];
    assign w_exp_r = r_exp + $signed({9'd0, w_m25[24]});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'd0;
            r_fflags <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_a <= a;
                    r_b <= b;
                end
                ST_ALIGN: begin
                    r_special  <= w_spec;
                    r_spec_res <= w_spec_res;
                    r_spec_ff  <= w_spec_ff;
                    r_sign     <= w_a_ge ? w_sa : w_sb;
                    r_sub      <= w_sa ^ w_sb;
                    r_exp      <= $signed({2'b00, w_big_exp});
                    r_sig_l    <= w_sig_big;
                    r_sig_s    <= w_sig_al;
                end
                ST_ADD: begin
                    r_sum <= r_sub ? ({1'b0, r_sig_l} - {1'b0, r_sig_s})
                                   : ({1'b0, r_sig_l} + {1'b0, r_sig_s});
                end
                ST_NORM: begin
                    r_zero <= (r_sum == 28'd0);
                    if (r_sum[27]) begin
                        r_sig <= {r_sum[27:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + 10'sd1;
                    end else begin
                        r_sig <= r_sum[26:0] << w_lsh;
                        r_exp <= r_exp - $signed({5'd0, w_lsh});
                    end
                end
                ST_ROUND: begin
                    if (r_special) begin
                        r_result <= r_spec_res;
                        r_fflags <= r_spec_ff;
                    end else if (r_zero) begin
                        r_result <= 32'd0;
                        r_fflags <= 5'd0;
                    end else if (w_exp_r <= 10'sd0) begin
                        r_result <= {r_sign, 31'd0};
                        r_fflags <= (5'd1 << FF_UF) | (5'd1 << FF_NX);
                    end else if (w_exp_r >= 10'sd255) begin
                        r_result <= {r_sign, EXP_MAX, 23'd0};
                        r_fflags <= (5'd1 << FF_OF) | (5'd1 << FF_NX);
                    end else begin
                        r_result <= {r_sign, w_exp_r[7:0], w_man};
                        r_fflags <= {4'd0, |r_sig[2:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign fflags    = r_fflags;

endmodule

`default_nettype wire

// File: tb/tb_fp_sub.sv
// ============================================================================
// tb_fp_sub : scoreboard bench for fp_sub against an exact-arithmetic model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fp_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [4:0]  fflags;

    fp_sub dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .fflags    (fflags)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int bp_mode = 0;   // 0: always ready, 1: random, 2: held low

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    typedef struct {
        logic [31:0] r;
        logic [4:0]  f;
        int          acc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Exact reference: operands become integers in units of 2^-149, the
    // difference is formed exactly, then rounded to 24 bits (RNE).
    function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [4:0] f);
        logic        sx, sy, sgn, xnan, ynan, xinf, yinf, xz, yz, inexact;
        logic [299:0] mx, my, mag, kept, rem, half;
        int          p, e, sh;
        sx = x[31];
        sy = ~y[31];
        xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xinf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yinf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        xz   = (x[30:23] == 0);
        yz   = (y[30:23] == 0);
        f = 5'd0;
        r = 32'd0;
        if (xnan || ynan) begin
            r = 32'h7FC00000;
            f[4] = (xnan && !x[22]) || (ynan && !y[22]);
        end else if (xinf && yinf) begin
            if (sx == sy) r = {sx, 8'hFF, 23'd0};
            else begin r = 32'h7FC00000; f[4] = 1'b1; end
        end else if (xinf) r = {sx, 8'hFF, 23'd0};
        else if (yinf)     r = {sy, 8'hFF, 23'd0};
        else if (xz && yz) r = {sx & sy, 31'd0};
        else if (xz)       r = {sy, y[30:0]};
        else if (yz)       r = x;
        else begin
            mx = '0; mx[23:0] = {1'b1, x[22:0]}; mx = mx << (x[30:23] - 8'd1);
            my = '0; my[23:0] = {1'b1, y[22:0]}; my = my << (y[30:23] - 8'd1);
            if (sx == sy)     begin mag = mx + my; sgn = sx; end
            else if (mx > my) begin mag = mx - my; sgn = sx; end
            else if (my > mx) begin mag = my - mx; sgn = sy; end
            else begin mag = '0; sgn = 1'b0; end
            if (mag == 0) begin
                r = 32'd0;
            end else begin
                p = 0;
                for (int i = 0; i < 300; i++) if (mag[i]) p = i;
                e = p - 22;
                inexact = 1'b0;
                if (p > 23) begin
                    sh   = p - 23;
                    kept = mag >> sh;
                    rem  = mag & ((300'd1 << sh) - 300'd1);
                    half = 300'd1 << (sh - 1);
                    inexact = (rem != 0);
                    if (rem > half || (rem == half && kept[0])) kept = kept + 300'd1;
                end else begin
                    kept = mag << (23 - p);
                end
                if (kept[24]) begin kept = kept >> 1; e = e + 1; end
                if (e <= 0)        begin r = {sgn, 31'd0};           f = 5'b00011; end
                else if (e >= 255) begin r = {sgn, 8'hFF, 23'd0};    f = 5'b00101; end
                else               begin r = {sgn, 8'(e), kept[22:0]}; f = {4'd0, inexact}; end
            end
        end
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [4:0] ef);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout_fail("send_wait_in_ready");
            return;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        q.push_back('{er, ef, cyc});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic send_model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] er;
        logic [4:0]  ef;
        ref_sub(x, y, er, ef);
        send(x, y, er, ef);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) timeout_fail("drain");
    endtask

    // Monitor: latency on each new result, stability under backpressure,
    // and scoreboard comparison on every output handshake.
    logic        prev_v = 1'b0, prev_rdy = 1'b0;
    logic [31:0] prev_r = 32'd0;
    logic [4:0]  prev_f = 5'd0;
    exp_t        e_pop;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
                if (!prev_v) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got %0h with nothing outstanding", result);
                    end else begin
                        chk("latency", 64'(cyc - q[0].acc), 64'd5);
                    end
                end else if (!prev_rdy) begin
                    chk("hold_result", 64'(result), 64'(prev_r));
                    chk("hold_fflags", 64'(fflags), 64'(prev_f));
                end
                if (out_ready && q.size() > 0) begin
                    e_pop = q.pop_front();
                    chk("result", 64'(result), 64'(e_pop.r));
                    chk("fflags", 64'(fflags), 64'(e_pop.f));
                end
            end
            prev_v   = out_valid;
            prev_rdy = out_ready;
            prev_r   = result;
            prev_f   = fflags;
        end
    end

    typedef struct {
        logic [31:0] x, y, r;
        logic [4:0]  f;
    } vec_t;

    vec_t dir[$] = '{
        '{32'h40400000, 32'h3F800000, 32'h40000000, 5'h00},
        '{32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 5'h00},
        '{32'h3F800000, 32'h3F800000, 32'h00000000, 5'h00},
        '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'h10},
        '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 5'h10},
        '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5'h05},
        '{32'h80000000, 32'h00000000, 32'h80000000, 5'h00},
        '{32'h00000000, 32'h00000000, 32'h00000000, 5'h00},
        '{32'h7F800000, 32'h3F800000, 32'h7F800000, 5'h00},
        '{32'h3F800000, 32'h7F800000, 32'hFF800000, 5'h00},
        '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00},
        '{32'h00800001, 32'h00800000, 32'h00000000, 5'h03},
        '{32'h00400000, 32'h3F800000, 32'hBF800000, 5'h00},
        '{32'h3F800000, 32'h00400000, 32'h3F800000, 5'h00},
        '{32'h3F800000, 32'h32800000, 32'h3F800000, 5'h01},
        '{32'h3F800000, 32'hB3800000, 32'h3F800000, 5'h01}
    };

    logic [31:0] specials[7] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                                 32'hFF800000, 32'h7FC00000, 32'h7FA00001, 32'h00000123};

    function automatic logic [31:0] mk(input logic s, input int e);
        return {s, 8'(e), 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] x, y;
        int          ea, eb, n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result",    64'(result),    64'd0);
        chk("reset_fflags",    64'(fflags),    64'd0);

        foreach (dir[i]) send(dir[i].x, dir[i].y, dir[i].r, dir[i].f);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            ea = $urandom_range(1, 254);
            eb = ea + $urandom_range(0, 40) - 20;
            if (eb < 1)   eb = 1;
            if (eb > 254) eb = 254;
            x = mk(1'($urandom), ea);
            y = mk(1'($urandom), eb);
            case ($urandom_range(0, 9))
                0: x = specials[$urandom_range(0, 6)];
                1: y = specials[$urandom_range(0, 6)];
                2: y = {1'($urandom), x[30:0]};
                3: begin x = mk(1'($urandom), $urandom_range(250, 254));
                         y = mk(1'($urandom), $urandom_range(250, 254)); end
                4: begin x = mk(1'($urandom), $urandom_range(1, 4));
                         y = {~x[31], x[30:8], 8'($urandom)}; end
                default: ;
            endcase
            send_model(x, y);
        end
        drain();

        // Held backpressure in DONE, then release.
        bp_mode = 2;
        send(32'h40400000, 32'h3F800000, 32'h40000000, 5'h00);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail("bp_wait_out_valid");
        repeat (4) begin
            @(negedge clk);
            chk("bp_out_valid_held", 64'(out_valid), 64'd1);
        end
        bp_mode = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after_release", 64'(in_ready),  64'd1);
        chk("bp_out_valid_after_release", 64'(out_valid), 64'd0);
        drain();

        // Reset while the operation sits in NORM.
        send(32'h40400000, 32'h3F800000, 32'h40000000, 5'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_result",    64'(result),    64'd0);
        chk("abort_fflags",    64'(fflags),    64'd0);
        repeat (10) begin
            @(negedge clk);
            chk("abort_no_output", 64'(out_valid), 64'd0);
        end

        send(32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 5'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
